// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Purpose  : Shared types and constants for the 5-stage CPU pipeline control.
//            wb_sel_t   - write-back source select of an instruction
//            hz_state_t - hazard sequencer state encoding
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2,
    ERR      = 2'd3
  } hz_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_wait_timer
// Purpose  : Counts memory wait cycles for the hazard sequencer.
//            clr has priority over inc. expire is high while the count
//            equals MEM_TMO.
// Ports    : clk, rst (async, active-high)
//            clr    in  clear the count to zero
//            inc    in  add one to the count
//            expire out count has reached MEM_TMO
// Revision : 1.0  initial release
// ============================================================================
module hazard_wait_timer #(
  parameter int MEM_TMO = 15,
  parameter int TMO_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [TMO_W-1:0] wait_cnt_q;
  logic [TMO_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc) begin
      wait_cnt_d = wait_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expire = (wait_cnt_q == TMO_W'(MEM_TMO));

endmodule : hazard_wait_timer
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencer for the 5-stage CPU. Generates stall/flush
//            controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers
//            from load-use hazards, EX redirects, multi-cycle memory
//            accesses (with timeout to bus error) and HALT.
//            All stall/flush outputs are combinational (Mealy).
// Ports    : clk, rst (async, active-high)
//            id_rs1/id_rs2, id_rs1_used/id_rs2_used  ID source registers
//            ex_reg_dst, ex_reg_wr, ex_wb_sel         EX destination info
//            ex_redirect   EX taken branch/jump
//            mem_req/mem_ready  MEM access handshake
//            id_halt       ID decodes HALT
//            *_stall / *_flush  pipeline register controls
//            halted, bus_err    status (bus_err sticky until reset)
// Options  : HAZ_PERF_CNT_EN adds stall_cycles / flush_events counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_TMO    = 15,
  parameter int TMO_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_reg_dst,
  input  logic                  ex_reg_wr,
  input  logic [1:0]            ex_wb_sel,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  id_halt,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  halted,
  output logic                  bus_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  import cpu_pkg::*;

  hz_state_t state_q;
  hz_state_t state_d;

  logic mem_hold;
  logic load_use;
  logic tmr_clr;
  logic tmr_inc;
  logic tmr_expire;

  hazard_wait_timer #(
    .MEM_TMO (MEM_TMO),
    .TMO_W   (TMO_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (tmr_expire)
  );

  assign mem_hold = mem_req & ~mem_ready;

  // A load in EX whose result the ID instruction needs; x0 never hazards.
  assign load_use = (wb_sel_t'(ex_wb_sel) == WB_MEM) && ex_reg_wr &&
                    (ex_reg_dst != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_reg_dst)) ||
                     (id_rs2_used && (id_rs2 == ex_reg_dst)));

  always_comb begin
    state_d      = state_q;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    case (state_q)
      ERR: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end
      HALT: begin
        // Front end frozen, bubbles fed into EX so older instrs drain.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: begin // RUN, MEM_WAIT
        if (mem_hold) begin
          // EX is frozen too, so a pending redirect re-presents on release.
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
          if (tmr_expire) begin
            state_d = ERR;
          end else begin
            tmr_inc = 1'b1;
            state_d = MEM_WAIT;
          end
        end else begin
          // Memory released (or idle): normal hazard handling this cycle.
          tmr_clr = 1'b1;
          state_d = RUN;
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use || id_halt) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (!load_use) begin
              state_d = HALT;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted  = (state_q == HALT);
  assign bus_err = (state_q == ERR);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_events_q;
  logic [31:0] flush_events_d;

  // Counters freeze once the core has taken a bus error.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (state_q != ERR) begin
      if (pc_stall) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (if_id_flush) begin
        flush_events_d = flush_events_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Each applied cycle pushes
//            its expected output vector to a scoreboard queue; a negedge
//            monitor pops and compares against the DUT outputs.
//            Vector layout: {pc,if_id,id_ex,ex_mem,mem_wb stall,
//                            if_id,id_ex,ex_mem,mem_wb flush, halted, bus_err}
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  import cpu_pkg::*;

  localparam logic [10:0] E_NONE   = 11'b00000_0000_00;
  localparam logic [10:0] E_LU     = 11'b11000_0100_00;
  localparam logic [10:0] E_MH     = 11'b11110_0001_00;
  localparam logic [10:0] E_RD     = 11'b00000_1100_00;
  localparam logic [10:0] E_HALTED = 11'b11000_0100_10;
  localparam logic [10:0] E_ERR    = 11'b11111_0000_01;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_reg_dst;
  logic       id_rs1_used, id_rs2_used, ex_reg_wr;
  logic [1:0] ex_wb_sel;
  logic       ex_redirect, mem_req, mem_ready, id_halt;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       halted, bus_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  int unsigned exp_stalls = 0;
  int unsigned exp_flushes = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .MEM_TMO(15), .TMO_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_reg_dst   (ex_reg_dst),
    .ex_reg_wr    (ex_reg_wr),
    .ex_wb_sel    (ex_wb_sel),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .id_halt      (id_halt),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_stall (mem_wb_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted),
    .bus_err      (bus_err)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: compare one expected vector per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {21'd0, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, bus_err},
          {21'd0, e});
`ifdef HAZ_PERF_CNT_EN
      if (rst) begin
        exp_stalls  = 0;
        exp_flushes = 0;
      end
      chk({t, "_stallcnt"}, stall_cycles, exp_stalls);
      chk({t, "_flushcnt"}, flush_events, exp_flushes);
      if (!rst && !e[0]) begin
        exp_stalls  += e[10];
        exp_flushes += e[5];
      end
`endif
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_reg_dst = 5'd0; ex_reg_wr = 1'b0; ex_wb_sel = WB_ALU;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; id_halt = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_wb_sel = WB_MEM; ex_reg_wr = 1'b1; ex_reg_dst = r;
    id_rs1 = r; id_rs1_used = 1'b1;
  endtask

  // Apply current inputs for one cycle and queue the expected outputs.
  task automatic cyc(input logic [10:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc(E_NONE, "reset");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(E_NONE, "reset_state");
    rst = 1'b0;
    cyc(E_NONE, "idle");

    // Load-use on rs1, then EX holds a bubble
    set_load_use(5'd5);
    cyc(E_LU, "lu_rs1");
    ex_reg_wr = 1'b0; ex_wb_sel = WB_ALU; ex_reg_dst = 5'd0;
    cyc(E_NONE, "lu_after");
    // Load-use on rs2
    idle();
    ex_wb_sel = WB_MEM; ex_reg_wr = 1'b1; ex_reg_dst = 5'd7;
    id_rs2 = 5'd7; id_rs2_used = 1'b1;
    cyc(E_LU, "lu_rs2");

    // Non-hazards
    idle(); set_load_use(5'd0);
    cyc(E_NONE, "lu_dst0");
    idle(); set_load_use(5'd5); id_rs1_used = 1'b0;
    cyc(E_NONE, "lu_unused");
    idle(); set_load_use(5'd5); ex_wb_sel = WB_ALU;
    cyc(E_NONE, "alu_match");
    idle(); set_load_use(5'd5); ex_reg_wr = 1'b0;
    cyc(E_NONE, "load_nowr");

    // Memory wait 3 cycles then release
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc(E_MH, "mem_hold");
    mem_ready = 1'b1;
    cyc(E_NONE, "mem_release");
    idle();
    cyc(E_NONE, "mem_idle");

    // Redirect overrides load-use
    set_load_use(5'd9); ex_redirect = 1'b1;
    cyc(E_RD, "rd_over_lu");
    // Redirect during mem hold is ignored until release
    idle(); ex_redirect = 1'b1; mem_req = 1'b1;
    cyc(E_MH, "rd_in_hold");
    cyc(E_MH, "rd_in_hold");
    mem_ready = 1'b1;
    cyc(E_RD, "rd_release");
    idle();

    // Ready on the 15th wait cycle: no error
    mem_req = 1'b1;
    for (int i = 0; i < 14; i++) cyc(E_MH, "tmo15_hold");
    mem_ready = 1'b1;
    cyc(E_NONE, "tmo15_ready");
    idle();
    cyc(E_NONE, "tmo15_noerr");
    // Ready together with timeout (16th cycle): ready wins
    mem_req = 1'b1;
    for (int i = 0; i < 15; i++) cyc(E_MH, "tmo16_hold");
    mem_ready = 1'b1;
    cyc(E_NONE, "tmo16_ready");
    idle();
    cyc(E_NONE, "tmo16_noerr");
    // 16 cycles without ready: bus error
    mem_req = 1'b1;
    for (int i = 0; i < 16; i++) cyc(E_MH, "tmo_hold");
    cyc(E_ERR, "err");
    idle(); id_halt = 1'b1; mem_ready = 1'b1;
    cyc(E_ERR, "err_sticky");
    do_reset();
    cyc(E_NONE, "err_cleared");

    // Halt
    id_halt = 1'b1;
    cyc(E_LU, "halt_entry");
    idle();
    cyc(E_HALTED, "halted");
    mem_req = 1'b1; ex_redirect = 1'b1;
    cyc(E_HALTED, "halt_over_mem");
    idle();
    cyc(E_HALTED, "halted2");
    do_reset();
    set_load_use(5'd3);
    cyc(E_LU, "run_after_halt");
    idle();
    cyc(E_NONE, "final");

    if (exp_q.size() != 0) chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
